// File: rtl/pipelined_matrix_controller.sv
// pipelined_matrix_controller: registered ID/EX control decode with multi-cycle mul stall, flush and illegal detect
module pipelined_matrix_controller #(
    parameter int ALUOP_W = 4,
    parameter int MUL_LAT = 3,
    localparam int CNT_W = $clog2(MUL_LAT + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_instr_valid,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_func,
    input  logic               i_stall_in,
    input  logic               i_flush,
    output logic               o_reg_dst,
    output logic               o_reg_write,
    output logic               o_alu_src,
    output logic               o_alu_src2,
    output logic               o_alu_src_reg,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_pc_src,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_ctrl_valid,
    output logic               o_stall_out,
    output logic               o_illegal
);
    typedef enum logic {RUN, BUSY} state_t;
    localparam bit LONG = MUL_LAT > 1;
    localparam logic [8:0] F_R = 9'b110000000, F_SH = 9'b111100000, F_I = 9'b011000000;
    localparam logic [8:0] F_LW = 9'b011001010, F_SW = 9'b001000100, F_BNE = 9'b000000001;
    state_t r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [8:0] r_flags, w_next_flags, w_flags;
    logic [ALUOP_W-1:0] r_aluop, w_next_aluop, w_aluop;
    logic r_ctrl_valid, w_next_valid, r_illegal, w_next_illegal;
    logic w_legal, w_mul, w_accept;
    always_comb begin
        w_legal = 1'b1;
        w_mul = 1'b0;
        w_flags = '0;
        w_aluop = '0;
        case (i_opcode)
            6'b000000: begin
                w_flags = F_R;
                case (i_func)
                    6'b100000: w_aluop = ALUOP_W'(4'b0000);
                    6'b100010: w_aluop = ALUOP_W'(4'b0001);
                    6'b100100: w_aluop = ALUOP_W'(4'b0011);
                    6'b100101: w_aluop = ALUOP_W'(4'b0100);
                    6'b101010: w_aluop = ALUOP_W'(4'b0101);
                    6'b000000: begin w_flags = F_SH; w_aluop = ALUOP_W'(4'b1000); end
                    6'b000010: begin w_flags = F_SH; w_aluop = ALUOP_W'(4'b1001); end
                    6'b000110: w_aluop = ALUOP_W'(4'b1010);
                    default: begin w_legal = 1'b0; w_flags = '0; end
                endcase
            end
            6'b011100: begin
                w_flags = F_R;
                case (i_func)
                    6'b100001: w_aluop = ALUOP_W'(4'b1011);
                    6'b100000: w_aluop = ALUOP_W'(4'b1100);
                    6'b000010: begin w_aluop = ALUOP_W'(4'b0010); w_mul = 1'b1; end
                    default: begin w_legal = 1'b0; w_flags = '0; end
                endcase
            end
            6'b001000: w_flags = F_I;
            6'b001101: begin w_flags = F_I; w_aluop = ALUOP_W'(4'b0100); end
            6'b100011: w_flags = F_LW;
            6'b101011: w_flags = F_SW;
            6'b000101: begin w_flags = F_BNE; w_aluop = ALUOP_W'(4'b0111); end
            default: w_legal = 1'b0;
        endcase
    end
    assign w_accept = i_instr_valid & w_legal;
    // A long mul parks its bundle in the registers with ctrl_valid low; output gating hides it until done
    always_comb begin
        w_next_state = r_state;
        w_next_cnt = r_cnt;
        w_next_flags = r_flags;
        w_next_aluop = r_aluop;
        w_next_valid = r_ctrl_valid;
        w_next_illegal = 1'b0;
        if (i_flush) begin
            w_next_state = RUN;
            w_next_cnt = '0;
            w_next_flags = '0;
            w_next_aluop = '0;
            w_next_valid = 1'b0;
        end else if (!i_stall_in && r_state == BUSY) begin
            w_next_cnt = r_cnt - 1'b1;
            w_next_state = (r_cnt == CNT_W'(1)) ? RUN : BUSY;
            w_next_valid = (r_cnt == CNT_W'(1));
        end else if (!i_stall_in) begin
            w_next_flags = w_accept ? w_flags : '0;
            w_next_aluop = w_accept ? w_aluop : '0;
            w_next_valid = w_accept & ~(w_mul & LONG);
            w_next_illegal = i_instr_valid & ~w_legal;
            w_next_state = (w_accept & w_mul & LONG) ? BUSY : RUN;
            w_next_cnt = (w_accept & w_mul & LONG) ? CNT_W'(MUL_LAT - 1) : '0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
            r_cnt <= '0;
            r_flags <= '0;
            r_aluop <= '0;
            r_ctrl_valid <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt <= w_next_cnt;
            r_flags <= w_next_flags;
            r_aluop <= w_next_aluop;
            r_ctrl_valid <= w_next_valid;
            r_illegal <= w_next_illegal;
        end
    end
    assign o_reg_dst = r_flags[8];
    assign o_reg_write = r_flags[7] & r_ctrl_valid;
    assign o_alu_src = r_flags[6];
    assign o_alu_src2 = r_flags[5];
    assign o_alu_src_reg = r_flags[4];
    assign o_mem_read = r_flags[3] & r_ctrl_valid;
    assign o_mem_write = r_flags[2] & r_ctrl_valid;
    assign o_mem_to_reg = r_flags[1];
    assign o_pc_src = r_flags[0] & r_ctrl_valid;
    assign o_alu_op = r_aluop;
    assign o_ctrl_valid = r_ctrl_valid;
    assign o_stall_out = (r_state == BUSY);
    assign o_illegal = r_illegal;
endmodule

// File: tb/tb_pipelined_matrix_controller.sv
// tb_pipelined_matrix_controller: scoreboard bench, MUL_LAT=3 instance plus a MUL_LAT=1 instance
module tb_pipelined_matrix_controller;
    logic clk = 1'b0, rst, iv, iv1, stall, flush;
    logic [5:0] op, fn;
    logic rd0, rw0, as0, as20, asr0, mr0, mw0, mtr0, pcs0, cv0, so0, il0;
    logic rd1, rw1, as1, as21, asr1, mr1, mw1, mtr1, pcs1, cv1, so1, il1;
    logic [3:0] aop0, aop1;
    logic [14:0] v0, v1;
    logic rst_q = 1'b0;
    int cyc = 0, checks = 0, errors = 0, c;
    typedef struct {int c; logic [14:0] v;} exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    bit stall_cyc[int];
    localparam logic [8:0] F_R = 9'b110000000, F_SH = 9'b111100000, F_I = 9'b011000000;
    localparam logic [8:0] F_LW = 9'b011001010, F_SW = 9'b001000100, F_BNE = 9'b000000001;

    pipelined_matrix_controller #(.ALUOP_W(4), .MUL_LAT(3)) u0 (
        .i_clk(clk), .i_reset(rst), .i_instr_valid(iv), .i_opcode(op), .i_func(fn),
        .i_stall_in(stall), .i_flush(flush),
        .o_reg_dst(rd0), .o_reg_write(rw0), .o_alu_src(as0), .o_alu_src2(as20), .o_alu_src_reg(asr0),
        .o_mem_read(mr0), .o_mem_write(mw0), .o_mem_to_reg(mtr0), .o_pc_src(pcs0), .o_alu_op(aop0),
        .o_ctrl_valid(cv0), .o_stall_out(so0), .o_illegal(il0));
    pipelined_matrix_controller #(.ALUOP_W(4), .MUL_LAT(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_instr_valid(iv1), .i_opcode(op), .i_func(fn),
        .i_stall_in(stall), .i_flush(flush),
        .o_reg_dst(rd1), .o_reg_write(rw1), .o_alu_src(as1), .o_alu_src2(as21), .o_alu_src_reg(asr1),
        .o_mem_read(mr1), .o_mem_write(mw1), .o_mem_to_reg(mtr1), .o_pc_src(pcs1), .o_alu_op(aop1),
        .o_ctrl_valid(cv1), .o_stall_out(so1), .o_illegal(il1));

    assign v0 = {il0, cv0, rd0, rw0, as0, as20, asr0, mr0, mw0, mtr0, pcs0, aop0};
    assign v1 = {il1, cv1, rd1, rw1, as1, as21, asr1, mr1, mw1, mtr1, pcs1, aop1};

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_q <= rst;
    end

    function automatic logic [14:0] ev(logic ill, logic val, logic [8:0] f, logic [3:0] a);
        return {ill, val, f, a};
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: pops an expectation whenever an instance presents valid control or an illegal pulse
    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_u0", 32'({v0, so0}), 32'd0);
            chk("reset_u1", 32'({v1, so1}), 32'd0);
        end else begin
            chk("stall_out_u0", 32'(so0), 32'(stall_cyc.exists(cyc)));
            chk("stall_out_u1", 32'(so1), 32'd0);
            if (!cv0) chk("gated_enables_u0", 32'({rw0, mr0, mw0, pcs0}), 32'd0);
            if (cv0 || il0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_u0", 32'(v0), 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    chk("cycle_u0", 32'(cyc), 32'(e0.c));
                    chk("bundle_u0", 32'(v0), 32'(e0.v));
                end
            end
            if (cv1 || il1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_u1", 32'(v1), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("cycle_u1", 32'(cyc), 32'(e1.c));
                    chk("bundle_u1", 32'(v1), 32'(e1.v));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] o, input logic [5:0] f, input int lat, input logic [14:0] v);
        if (lat > 0) q0.push_back('{cyc + lat, v});
        op = o;
        fn = f;
        iv = 1'b1;
        tick();
        iv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; iv1 = 1'b0; stall = 1'b0; flush = 1'b0; op = '0; fn = '0;
        tick();
        tick();
        rst = 1'b0;
        issue(6'b000000, 6'b100000, 1, ev(0, 1, F_R, 4'b0000));
        issue(6'b000000, 6'b100010, 1, ev(0, 1, F_R, 4'b0001));
        issue(6'b000000, 6'b100100, 1, ev(0, 1, F_R, 4'b0011));
        issue(6'b000000, 6'b100101, 1, ev(0, 1, F_R, 4'b0100));
        issue(6'b000000, 6'b101010, 1, ev(0, 1, F_R, 4'b0101));
        issue(6'b000000, 6'b000000, 1, ev(0, 1, F_SH, 4'b1000));
        issue(6'b000000, 6'b000010, 1, ev(0, 1, F_SH, 4'b1001));
        issue(6'b000000, 6'b000110, 1, ev(0, 1, F_R, 4'b1010));
        issue(6'b011100, 6'b100001, 1, ev(0, 1, F_R, 4'b1011));
        issue(6'b011100, 6'b100000, 1, ev(0, 1, F_R, 4'b1100));
        issue(6'b001000, 6'b000000, 1, ev(0, 1, F_I, 4'b0000));
        issue(6'b001101, 6'b111111, 1, ev(0, 1, F_I, 4'b0100));
        issue(6'b100011, 6'b000000, 1, ev(0, 1, F_LW, 4'b0000));
        issue(6'b101011, 6'b000000, 1, ev(0, 1, F_SW, 4'b0000));
        issue(6'b111111, 6'b000000, 1, ev(1, 0, 9'd0, 4'b0000));
        issue(6'b000000, 6'b111111, 1, ev(1, 0, 9'd0, 4'b0000));
        tick();
        // mul, MUL_LAT=3, with instructions offered during BUSY that must be ignored
        c = cyc;
        stall_cyc[c + 1] = 1'b1;
        stall_cyc[c + 2] = 1'b1;
        issue(6'b011100, 6'b000010, 3, ev(0, 1, F_R, 4'b0010));
        op = 6'b000000; fn = 6'b100000; iv = 1'b1;
        tick();
        tick();
        iv = 1'b0;
        tick();
        // mul on the single-cycle instance, back to back
        op = 6'b011100; fn = 6'b000010; iv1 = 1'b1;
        q1.push_back('{cyc + 1, ev(0, 1, F_R, 4'b0010)});
        tick();
        q1.push_back('{cyc + 1, ev(0, 1, F_R, 4'b0010)});
        tick();
        iv1 = 1'b0;
        tick();
        // flush on first BUSY cycle, then an add proves the FSM is back in RUN
        c = cyc;
        stall_cyc[c + 1] = 1'b1;
        issue(6'b011100, 6'b000010, 0, '0);
        flush = 1'b1; op = 6'b000000; fn = 6'b100000; iv = 1'b1;
        tick();
        flush = 1'b0; iv = 1'b0;
        issue(6'b000000, 6'b100010, 1, ev(0, 1, F_R, 4'b0001));
        tick();
        // reset on first BUSY cycle
        c = cyc;
        stall_cyc[c + 1] = 1'b1;
        issue(6'b011100, 6'b000010, 0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        // bne held by three stall_in cycles while another instruction is offered
        c = cyc;
        issue(6'b000101, 6'b000000, 1, ev(0, 1, F_BNE, 4'b0111));
        for (int i = 2; i <= 4; i++) q0.push_back('{c + i, ev(0, 1, F_BNE, 4'b0111)});
        stall = 1'b1; op = 6'b000000; fn = 6'b100000; iv = 1'b1;
        tick();
        tick();
        tick();
        stall = 1'b0; iv = 1'b0;
        tick();
        // stall_in clears the illegal pulse without accepting anything
        issue(6'b111111, 6'b000000, 1, ev(1, 0, 9'd0, 4'b0000));
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        tick();
        // stall_in during BUSY delays mul completion by the stall length
        c = cyc;
        for (int i = 1; i <= 4; i++) stall_cyc[c + i] = 1'b1;
        issue(6'b011100, 6'b000010, 5, ev(0, 1, F_R, 4'b0010));
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("drain_u0", 32'(q0.size()), 32'd0);
        chk("drain_u1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_matrix_controller.md
Name: pipelined_matrix_controller

Overview:
Registered, parametrised successor to the combinational matrix controller. Decodes opcode/func into the datapath control bundle, registers it for one ID/EX boundary, and stalls fetch for a configurable number of cycles on multi-cycle mul. Adds flush, downstream stall, and illegal-instruction detection. Sits between the IF/ID register and the EX stage.

Parameters:
ALUOP_W, 4, width of ALUOp
MUL_LAT, 3, total mul latency in cycles from accept to ctrl_valid (>=1; 1 = single-cycle, no stall)
CNT_W, $clog2(MUL_LAT+1), busy counter width (derived, not overridden)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
instr_valid  in  1  opcode/func valid this cycle
opcode  in  6  instruction [31:26]
func  in  6  instruction [5:0]
stall_in  in  1  downstream hold; freeze all state
flush  in  1  branch-taken squash
RegDst, RegWrite, ALUSrc, ALUSrc2, ALUSrcReg, MemRead, MemWrite, MemtoReg, PCSrc  out  1 each  registered control
ALUOp  out  ALUOP_W  registered ALU operation
ctrl_valid  out  1  control bundle valid for EX this cycle
stall_out  out  1  hold PC and IF/ID register
illegal  out  1  one-cycle pulse, undecodable instruction accepted

Behaviour:
- Single clock Clk; Reset synchronous active-high. All outputs are registered.
- Reset: all outputs 0, ALUOp 0, state RUN, counter 0.
- Priority each edge: Reset > flush > stall_in > normal operation.
- Decode table (op/func -> ALUOp, flags):
  000000/100000 add 0000; /100010 sub 0001; /100100 and 0011; /100101 or 0100; /101010 slt 0101 (RegDst=1, RegWrite=1, rest 0).
  000000/000000 sll 1000, /000010 srl 1001 (ALUSrc=1, ALUSrc2=1, RegDst=1, RegWrite=1); 000000/000110 rotr 1010 (R-type flags).
  011100/100001 clo 1011; /100000 clz 1100; /000010 mul 0010 (R-type flags; mul multi-cycle).
  001000 addi 0000, 001101 ori 0100 (ALUSrc=1, RegWrite=1, RegDst=0).
  100011 lw 0000 (ALUSrc, RegWrite, MemRead, MemtoReg). 101011 sw 0000 (ALUSrc, MemWrite). 000101 bne 0111 (PCSrc).
  Unlisted flags are 0. Every decoded signal is fully assigned; no latches.
- Gating: RegWrite, MemRead, MemWrite, PCSrc are forced 0 whenever ctrl_valid=0.
- FSM states RUN, BUSY.
  RUN, instr_valid=1, legal non-mul (or mul with MUL_LAT=1): next cycle bundle and ctrl_valid=1; latency 1.
  RUN, mul with MUL_LAT>1: register bundle, ctrl_valid=0, cnt<=MUL_LAT-1, go to BUSY.
  BUSY: stall_out=1, instr inputs ignored, cnt decrements each edge. At an edge with cnt==1, go to RUN with ctrl_valid=1. BUSY lasts MUL_LAT-1 cycles; ctrl_valid rises exactly MUL_LAT cycles after accept.
  RUN, instr_valid=0: ctrl_valid=0, enables 0.
- stall_out = (state==BUSY); 0 in RUN.
- Illegal op/func in RUN with instr_valid: NOP bundle (all 0), ctrl_valid=0, illegal=1 for one cycle, stay RUN.
- stall_in=1: outputs, state, and cnt hold; illegal is cleared to 0. No new instruction is accepted.
- flush=1: next cycle ctrl_valid=0, enables 0, illegal=0. From BUSY, abort to RUN and cnt<=0. The flushing cycle's instruction is discarded.
- Reset mid-BUSY: return to RUN with all outputs 0 on that edge.

Test Plan:
- Reset held 2 cycles, then add (000000/100000) valid -> next cycle ctrl_valid=1, ALUOp=0000, RegDst=1, RegWrite=1, stall_out=0.
- mul (011100/000010) with MUL_LAT=3 -> stall_out=1 for 2 cycles; ctrl_valid=1, ALUOp=0010, RegWrite=1 exactly 3 cycles after accept. With MUL_LAT=1 -> 1-cycle latency, stall_out never 1.
- lw (100011) then sw (101011) back-to-back -> MemRead=1/MemtoReg=1 then MemWrite=1/RegWrite=0 on consecutive cycles. ori (001101) -> ALUOp=0100, ALUSrc=1.
- opcode 111111 valid -> illegal=1 for 1 cycle, ctrl_valid=0, all enables 0.
- mul accepted, flush on first BUSY cycle -> next cycle state RUN, stall_out=0, ctrl_valid=0. Repeat with Reset instead -> all outputs 0.
- bne (000101) with stall_in=1 for 3 cycles -> PCSrc=1, ALUOp=0111 held stable across the stall. With stall_in during mul BUSY -> completion delayed by the stall length.
